// File: rtl/fc_layer_engine.sv
// fc_layer_engine
// Fully-connected layer evaluator. It streams one activation vector against
// NCH parallel weight banks, keeps one signed accumulator per output neuron,
// then writes NCH post-processed results (shift, optional ReLU, saturate).
//
// Ports
//   clk, xrst            clock, asynchronous active-low reset
//   start                begin an evaluation (accepted in IDLE only)
//   len, shift, relu_en  vector length, right-shift amount, ReLU select (latched at start)
//   x_raddr / x_rdata    activation memory read port (data one cycle after address)
//   w_raddr / w_rdata    per-bank weight read ports, bank k in slice k
//   y_we/y_waddr/y_wdata result write port, one neuron per cycle
//   finish               one-cycle completion pulse
module fc_layer_engine #(
    parameter int NCH   = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int ACCW  = 2*DW+AW,
    localparam int NW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  xrst,
    input  logic                  start,
    input  logic [AW:0]           len,
    input  logic [4:0]            shift,
    input  logic                  relu_en,
    output logic [AW-1:0]         x_raddr,
    input  logic signed [DW-1:0]  x_rdata,
    output logic [NCH*AW-1:0]     w_raddr,
    input  logic [NCH*DW-1:0]     w_rdata,
    output logic                  y_we,
    output logic [NW-1:0]         y_waddr,
    output logic signed [DW-1:0]  y_wdata,
    output logic                  finish
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

    localparam logic [AW:0]              DEPTH_L = (AW+1)'(DEPTH);
    localparam logic signed [ACCW-1:0]   Y_MAX   = ACCW'((2**(DW-1)) - 1);
    localparam logic signed [ACCW-1:0]   Y_MIN   = ACCW'(-(2**(DW-1)));

    state_t                   state_q, state_d;
    logic [AW:0]              len_q, len_d;
    logic [4:0]               shift_q, shift_d;
    logic                     relu_q, relu_d;
    logic [AW:0]              cnt_q, cnt_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic                     rd_vld_q, rd_vld_d;
    logic signed [ACCW-1:0]   acc_q [NCH];
    logic signed [ACCW-1:0]   acc_d [NCH];
    logic signed [2*DW-1:0]   prod [NCH];
    logic                     y_we_q, y_we_d;
    logic [NW-1:0]            y_waddr_q, y_waddr_d;
    logic signed [DW-1:0]     y_wdata_q, y_wdata_d;
    logic                     finish_q, finish_d;
    logic [NW-1:0]            wnext;
    logic [AW:0]              len_clamped;

    // Floor shift, optional ReLU, then clamp into the DW-bit signed range.
    function automatic logic signed [DW-1:0] post_proc(
        input logic signed [ACCW-1:0] a,
        input logic [4:0]             sh,
        input logic                   relu
    );
        logic signed [ACCW-1:0] s;
        logic signed [DW-1:0]   r;
        s = a >>> sh;
        if (relu && (s < 0)) begin
            s = '0;
        end
        if (s > Y_MAX) begin
            r = DW'(Y_MAX);
        end else if (s < Y_MIN) begin
            r = DW'(Y_MIN);
        end else begin
            r = DW'(s);
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        shift_d   = shift_q;
        relu_d    = relu_q;
        cnt_d     = cnt_q;
        addr_d    = '0;
        y_we_d    = 1'b0;
        y_waddr_d = '0;
        y_wdata_d = '0;
        finish_d  = 1'b0;
        wnext     = y_waddr_q + NW'(1);
        // Read data for an address issued in a RUN cycle is valid in the
        // following cycle, so accumulation trails RUN by one cycle.
        rd_vld_d  = (state_q == RUN);
        len_clamped = (len > DEPTH_L) ? DEPTH_L : len;

        for (int k = 0; k < NCH; k++) begin
            prod[k]  = (2*DW)'(x_rdata) * (2*DW)'($signed(w_rdata[k*DW +: DW]));
            acc_d[k] = rd_vld_q ? (acc_q[k] + ACCW'(prod[k])) : acc_q[k];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len_clamped;
                    shift_d = shift;
                    relu_d  = relu_en;
                    for (int k = 0; k < NCH; k++) begin
                        acc_d[k] = '0;
                    end
                    if (len_clamped != '0) begin
                        state_d = RUN;
                        addr_d  = '0;
                        cnt_d   = (AW+1)'(1);
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            RUN: begin
                // cnt_q counts addresses already issued.
                if (cnt_q == len_q) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = cnt_q[AW-1:0];
                    cnt_d  = cnt_q + (AW+1)'(1);
                end
            end
            DRAIN: begin
                // The final accumulate lands on this same edge, so the first
                // result is taken from the next-state accumulator value.
                state_d   = WRITE;
                y_we_d    = 1'b1;
                y_waddr_d = '0;
                y_wdata_d = post_proc(acc_d[0], shift_q, relu_q);
            end
            WRITE: begin
                if (y_waddr_q == NW'(NCH-1)) begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                end else begin
                    y_we_d    = 1'b1;
                    y_waddr_d = wnext;
                    y_wdata_d = post_proc(acc_d[wnext], shift_q, relu_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            rd_vld_q  <= 1'b0;
            y_we_q    <= 1'b0;
            y_waddr_q <= '0;
            y_wdata_q <= '0;
            finish_q  <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            shift_q   <= shift_d;
            relu_q    <= relu_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rd_vld_q  <= rd_vld_d;
            y_we_q    <= y_we_d;
            y_waddr_q <= y_waddr_d;
            y_wdata_q <= y_wdata_d;
            finish_q  <= finish_d;
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    // Every bank reads the same index, so one address register feeds all.
    assign x_raddr = addr_q;
    assign w_raddr = {NCH{addr_q}};
    assign y_we    = y_we_q;
    assign y_waddr = y_waddr_q;
    assign y_wdata = y_wdata_q;
    assign finish  = finish_q;

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine
// Self-checking bench for fc_layer_engine. Activation and weight memories are
// modelled as synchronous-read arrays; expected results come from a plain
// dot-product / floor-divide / clamp reference model.
module tb_fc_layer_engine;

    localparam int NCH   = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int NW    = 4;

    logic                  clk;
    logic                  xrst;
    logic                  start;
    logic [AW:0]           len;
    logic [4:0]            shift;
    logic                  relu_en;
    logic [AW-1:0]         x_raddr;
    logic signed [DW-1:0]  x_rdata;
    logic [NCH*AW-1:0]     w_raddr;
    logic [NCH*DW-1:0]     w_rdata;
    logic                  y_we;
    logic [NW-1:0]         y_waddr;
    logic signed [DW-1:0]  y_wdata;
    logic                  finish;

    logic signed [DW-1:0]  xmem [DEPTH];
    logic signed [DW-1:0]  wmem [NCH][DEPTH];
    int                    last_y [NCH];

    int checks   = 0;
    int failures = 0;

    fc_layer_engine #(.NCH(NCH), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .xrst    (xrst),
        .start   (start),
        .len     (len),
        .shift   (shift),
        .relu_en (relu_en),
        .x_raddr (x_raddr),
        .x_rdata (x_rdata),
        .w_raddr (w_raddr),
        .w_rdata (w_rdata),
        .y_we    (y_we),
        .y_waddr (y_waddr),
        .y_wdata (y_wdata),
        .finish  (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data appears one cycle after the address.
    always @(posedge clk) begin
        x_rdata <= xmem[x_raddr];
        for (int k = 0; k < NCH; k++) begin
            w_rdata[k*DW +: DW] <= wmem[k][w_raddr[k*AW +: AW]];
        end
    end

    // Reference: exact dot product, floor division by 2^sh, ReLU, clamp.
    function automatic int ref_y(input int k, input int l, input int sh, input bit relu);
        longint acc, d, q;
        acc = 0;
        for (int i = 0; i < l; i++) begin
            acc += longint'(xmem[i]) * longint'(wmem[k][i]);
        end
        d = longint'(1) << sh;
        q = acc / d;
        if (((acc % d) != 0) && (acc < 0)) q = q - 1;
        if (relu && (q < 0)) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < DEPTH; i++) begin
            xmem[i] = 8'sd1;
            for (int k = 0; k < NCH; k++) wmem[k][i] = DW'(k - 8);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            xmem[i] = DW'($urandom);
            for (int k = 0; k < NCH; k++) wmem[k][i] = DW'($urandom);
        end
    endtask

    // Runs one evaluation, records per-cycle behaviour and compares it with
    // the reference timing and values. Pulse re-asserts start in RUN, WRITE
    // and DONE; tail is how many cycles to keep watching after finish.
    task automatic run_layer(input string name, input int l_in, input int sh,
                             input bit relu, input bit pulse, input int tail);
        int lc, c, lat, nfin, bad_at, exp_x;
        int xq[$];
        bit wokq[$];
        int wa[$];
        int wv[$];
        int wc[$];
        lc   = (l_in > DEPTH) ? DEPTH : l_in;
        lat  = -1;
        nfin = 0;
        @(negedge clk);
        len     = (AW+1)'(l_in);
        shift   = 5'(sh);
        relu_en = relu;
        start   = 1'b1;
        @(posedge clk);
        c = 1;
        forever begin
            @(negedge clk);
            start = 1'b0;
            xq.push_back(int'(x_raddr));
            wokq.push_back(w_raddr == {NCH{x_raddr}});
            if (y_we) begin
                wa.push_back(int'(y_waddr));
                wv.push_back(int'(y_wdata));
                wc.push_back(c);
            end
            if (finish) begin
                nfin++;
                if (lat < 0) lat = c;
            end
            if (pulse && (c == 2 || c == lc + 4 || c == lat)) start = 1'b1;
            if (lat >= 0 && c >= lat + tail) break;
            if (c >= 400) break;
            @(posedge clk);
            c++;
        end
        start = 1'b0;

        checks++;
        if (lat != lc + NCH + 2) begin
            failures++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, lc + NCH + 2);
        end
        checks++;
        if (nfin != 1) begin
            failures++;
            $display("[TB] FAIL %s finish_count: got %0d expected 1", name, nfin);
        end
        checks++;
        if (wa.size() != NCH) begin
            failures++;
            $display("[TB] FAIL %s write_count: got %0d expected %0d", name, wa.size(), NCH);
        end
        for (int k = 0; k < NCH; k++) last_y[k] = 9999;
        for (int k = 0; k < wa.size() && k < NCH; k++) begin
            last_y[k] = wv[k];
            checks++;
            if (wa[k] != k || wc[k] != lc + 2 + k) begin
                failures++;
                $display("[TB] FAIL %s write_slot[%0d]: got addr %0d cycle %0d expected addr %0d cycle %0d",
                         name, k, wa[k], wc[k], k, lc + 2 + k);
            end
            checks++;
            if (wv[k] != ref_y(k, lc, sh, relu)) begin
                failures++;
                $display("[TB] FAIL %s y[%0d]: got %0d expected %0d", name, k, wv[k], ref_y(k, lc, sh, relu));
            end
        end
        bad_at = -1;
        exp_x  = 0;
        for (int i = 0; i < xq.size(); i++) begin
            exp_x = (i < lc) ? i : 0;
            if (bad_at < 0 && (xq[i] != exp_x || !wokq[i])) bad_at = i;
        end
        checks++;
        if (bad_at >= 0) begin
            failures++;
            $display("[TB] FAIL %s read_addr cycle %0d: got x %0d bank_match %0d expected x %0d bank_match 1",
                     name, bad_at + 1, xq[bad_at], wokq[bad_at], (bad_at < lc) ? bad_at : 0);
        end
    endtask

    task automatic test_reset();
        xrst = 1'b0;
        #3;
        checks++;
        if (x_raddr !== '0 || w_raddr !== '0 || y_we !== 1'b0 || y_waddr !== '0 ||
            y_wdata !== '0 || finish !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got x %0h w %0h we %b wa %0d wd %0d fin %b expected all zero",
                     x_raddr, w_raddr, y_we, y_waddr, y_wdata, finish);
        end
        repeat (2) @(negedge clk);
        xrst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (y_we !== 1'b0 || finish !== 1'b0 || x_raddr !== '0) begin
            failures++;
            $display("[TB] FAIL idle_outputs: got we %b fin %b x %0d expected 0 0 0", y_we, finish, x_raddr);
        end
    endtask

    task automatic test_ramp();
        fill_ramp();
        run_layer("ramp", 16, 0, 1'b0, 1'b0, 2);
        checks++;
        if (last_y[0] != -128 || last_y[7] != -16 || last_y[8] != 0 || last_y[15] != 112) begin
            failures++;
            $display("[TB] FAIL ramp_points: got %0d %0d %0d %0d expected -128 -16 0 112",
                     last_y[0], last_y[7], last_y[8], last_y[15]);
        end
    endtask

    task automatic test_small_relu();
        fill_random();
        xmem[0] = 8'sd2; xmem[1] = -8'sd3; xmem[2] = 8'sd4; xmem[3] = -8'sd1;
        for (int i = 0; i < DEPTH; i++) begin
            wmem[0][i] = 8'sd5;
            wmem[1][i] = -8'sd5;
        end
        run_layer("small", 4, 1, 1'b1, 1'b0, 2);
        checks++;
        if (last_y[0] != 5 || last_y[1] != 0) begin
            failures++;
            $display("[TB] FAIL small_points: got %0d %0d expected 5 0", last_y[0], last_y[1]);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < DEPTH; i++) begin
            xmem[i] = -8'sd128;
            for (int k = 0; k < NCH; k++) wmem[k][i] = -8'sd128;
        end
        run_layer("sat_shift0", 16, 0, 1'b0, 1'b0, 2);
        checks++;
        if (last_y[0] != 127 || last_y[15] != 127) begin
            failures++;
            $display("[TB] FAIL sat_points: got %0d %0d expected 127 127", last_y[0], last_y[15]);
        end
        run_layer("sat_shift18", 16, 18, 1'b0, 1'b0, 2);
        checks++;
        if (last_y[3] != 1) begin
            failures++;
            $display("[TB] FAIL sat_shift18_point: got %0d expected 1", last_y[3]);
        end
    endtask

    task automatic test_len_edges();
        fill_random();
        run_layer("len0", 0, 0, 1'b0, 1'b0, 2);
        checks++;
        if (last_y[0] != 0 || last_y[9] != 0) begin
            failures++;
            $display("[TB] FAIL len0_points: got %0d %0d expected 0 0", last_y[0], last_y[9]);
        end
        fill_ramp();
        run_layer("len31", 31, 0, 1'b0, 1'b0, 2);
        checks++;
        if (last_y[0] != -128 || last_y[15] != 112) begin
            failures++;
            $display("[TB] FAIL len31_points: got %0d %0d expected -128 112", last_y[0], last_y[15]);
        end
    endtask

    task automatic test_back_to_back();
        fill_ramp();
        run_layer("restart_ignored", 16, 0, 1'b0, 1'b1, 24);
    endtask

    task automatic test_reset_mid_write();
        int n, extra;
        fill_random();
        @(negedge clk);
        len = 5'd16; shift = 5'd2; relu_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(y_we === 1'b1 && y_waddr === 4'd5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("[TB] FAIL midwrite_reach: got no write to 5 in %0d cycles expected one", n);
        end
        xrst = 1'b0;
        #1;
        checks++;
        if (y_we !== 1'b0 || finish !== 1'b0 || y_waddr !== '0 || y_wdata !== '0) begin
            failures++;
            $display("[TB] FAIL midwrite_async: got we %b fin %b wa %0d wd %0d expected 0 0 0 0",
                     y_we, finish, y_waddr, y_wdata);
        end
        repeat (2) @(negedge clk);
        xrst  = 1'b1;
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (y_we === 1'b1 || finish === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("[TB] FAIL midwrite_abandon: got %0d active cycles expected 0", extra);
        end
        run_layer("after_reset", 10, 3, 1'b1, 1'b0, 2);
    endtask

    task automatic test_random();
        int l, sh;
        bit r;
        for (int t = 0; t < 4; t++) begin
            fill_random();
            l  = $urandom_range(0, 31);
            sh = $urandom_range(0, 20);
            r  = 1'($urandom);
            run_layer("random", l, sh, r, 1'b0, 2);
        end
    endtask

    initial begin
        start   = 1'b0;
        len     = '0;
        shift   = '0;
        relu_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            xmem[i] = '0;
            for (int k = 0; k < NCH; k++) wmem[k][i] = '0;
        end
        test_reset();
        test_ramp();
        test_small_relu();
        test_saturate();
        test_len_edges();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_layer_engine.md
FC_LAYER_ENGINE -- requirements
Module: fc_layer_engine

Interface
REQ-001 SHALL have parameter NCH, default 16, meaning number of parallel weight banks and output neurons.
REQ-002 SHALL have parameter DEPTH, default 16, meaning words per weight bank and maximum input vector length.
REQ-003 SHALL have parameter AW, default 4, meaning address width; SHALL equal clog2(DEPTH).
REQ-004 SHALL have parameter DW, default 8, meaning signed data width of activations, weights and outputs.
REQ-005 SHALL have parameter ACCW, default 2*DW+AW, meaning signed accumulator width.
REQ-006 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have port xrst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  input  1  begin one layer evaluation, sampled in IDLE only.
REQ-009 SHALL have port len  input  AW+1  input vector length, latched at start.
REQ-010 SHALL have port shift  input  5  arithmetic right-shift amount, latched at start.
REQ-011 SHALL have port relu_en  input  1  ReLU mode select, latched at start.
REQ-012 SHALL have port x_raddr  output  AW  activation memory read address.
REQ-013 SHALL have port x_rdata  input  DW  signed activation, valid one cycle after x_raddr.
REQ-014 SHALL have port w_raddr  output  NCH*AW  per-bank weight read addresses, bank k at bits [k*AW +: AW].
REQ-015 SHALL have port w_rdata  input  NCH*DW  per-bank signed weights, bank k at [k*DW +: DW], valid one cycle after address.
REQ-016 SHALL have ports y_we  output  1, y_waddr  output  clog2(NCH), y_wdata  output  DW  result write port.
REQ-017 SHALL have port finish  output  1  one-cycle done pulse.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN, WRITE, DONE; IDLE->RUN on start (len>0), IDLE->DRAIN on start with len==0.
REQ-019 SHALL clamp latched len to DEPTH when len>DEPTH, and clear all NCH accumulators on the start edge.
REQ-020 SHALL, in RUN, drive x_raddr and every bank address with i, i=0..len-1, one per cycle, registered outputs; RUN lasts len cycles, then DRAIN for 1 cycle.
REQ-021 SHALL accumulate acc[k] += x_rdata*w_rdata[k] (full signed DW*DW product, sign-extended to ACCW) on the edge after each read data becomes valid; last accumulate coincides with DRAIN->WRITE edge.
REQ-022 SHALL, in WRITE, emit one result per cycle for k=0..NCH-1: y_we=1, y_waddr=k, y_wdata=f(acc[k]); WRITE lasts exactly NCH cycles.
REQ-023 SHALL compute f as: arithmetic shift right by latched shift (floor toward -inf); if relu_en, negative -> 0; saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-024 SHALL assert finish for exactly one cycle in DONE, then return to IDLE; total latency from start-sampling edge to finish high = len+NCH+2 cycles (len clamped).
REQ-025 SHALL ignore start in any state other than IDLE; start high in the DONE cycle is not accepted until IDLE.
REQ-026 SHALL hold x_raddr and w_raddr at 0 and y_we at 0 outside RUN and WRITE respectively.
REQ-027 SHALL not saturate or wrap the accumulator; ACCW is sized so DEPTH full-scale products cannot overflow.

Reset
REQ-028 SHALL on xrst low, immediately and regardless of clock, force state IDLE, accumulators 0, x_raddr 0, w_raddr 0, y_we 0, y_waddr 0, y_wdata 0, finish 0.
REQ-029 SHALL, on reset asserted mid-operation, abandon the evaluation with no further writes or finish pulse; a new start after release runs normally.

Verification
REQ-030 Defaults, len=16, shift=0, relu_en=0, all x=1, bank k weights=k-8 -> y[k]=saturate(16*(k-8)): y0=-128, y7=-16, y8=0, y15=112; finish at cycle 34.
REQ-031 len=4, x=[2,-3,4,-1], bank0 w=[5,5,5,5], shift=1, relu_en=1 -> acc0=10, y0=5; bank with acc=-10 -> y=0; finish at cycle 22.
REQ-032 len=16, x=-128, w=-128 all banks, shift=0 -> acc=262144 (no overflow), every y=127; shift=18 -> y=1.
REQ-033 len=0 -> no RUN addresses, 16 writes of 0, finish at cycle 18; len=31 -> clamped to 16, behaves as REQ-030.
REQ-034 start pulsed again during RUN and WRITE -> ignored, exactly 16 writes and one finish; xrst low during WRITE at k=5 -> y_we drops immediately, no finish, next start completes normally.
